i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_sync_edge.sv | 40 ++++
 rtl/i2c_target.sv | 199 +++++++++++++++++++
 tb/tb_i2c_target.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared I2C state encodings and bus bit constants.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_ADDR_ACK  = 3'd2,
      S_RX_BYTE   = 3'd3,
      S_RX_ACK    = 3'd4,
      S_TX_BYTE   = 3'd5,
      S_TX_ACK    = 3'd6,
      S_WAIT_STOP = 3'd7
   } i2c_state_e;

   localparam logic       c_rw_write  = 1'b0;
   localparam logic       c_rw_read   = 1'b1;
   localparam logic       c_ack       = 1'b0;
   localparam logic       c_nack      = 1'b1;
   localparam logic [2:0] c_bitcnt_hi = 3'd7;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
// Module      : i2c_sync_edge
// Description : 2-flop synchronizer with rise/fall strobes; all flops reset to 1.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// Module      : i2c_target
// Description : I2C target (slave) with 7-bit address, byte write and read paths.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   input  logic [7:0] tx_data,
   output logic       busy
);

   logic w_scl_lvl, w_scl_rise, w_scl_fall;
   logic w_sda_lvl, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   i2c_sync_edge u_sync_scl (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_i     (scl),
      .level_o (w_scl_lvl),
      .rise_o  (w_scl_rise),
      .fall_o  (w_scl_fall)
   );

   i2c_sync_edge u_sync_sda (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_i     (sda),
      .level_o (w_sda_lvl),
      .rise_o  (w_sda_rise),
      .fall_o  (w_sda_fall)
   );

   assign w_start = w_sda_fall & w_scl_lvl;
   assign w_stop  = w_sda_rise & w_scl_lvl;

   i2c_state_e state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic       done_q, done_d;
   logic [7:0] shift_q, shift_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       busy_q, busy_d;

   // Open-drain: only ever pull low; release means high impedance.
   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bitcnt_q   <= 3'd0;
         done_q     <= 1'b0;
         shift_q    <= 8'h00;
         rw_q       <= c_rw_write;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         done_q     <= done_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      done_d     = done_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;

      if (w_start) begin
         state_d  = S_ADDR;
         bitcnt_d = c_bitcnt_hi;
         done_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (w_stop) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_RX_BYTE: begin
               if (w_scl_rise) begin
                  shift_d = {shift_q[6:0], w_sda_lvl};
                  if (bitcnt_q == 3'd0) done_d = 1'b1;
                  else                  bitcnt_d = bitcnt_q - 3'd1;
               end else if (w_scl_fall && done_q) begin
                  if (state_q == S_RX_BYTE) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = 1'b1;
                     state_d    = S_RX_ACK;
                  end else if (shift_q[7:1] == DEV_ADDR) begin
                     rw_d     = shift_q[0];
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     state_d  = S_ADDR_ACK;
                  end else begin
                     state_d  = S_WAIT_STOP;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_rise && rw_q == c_rw_read) tx_req_d = 1'b1;
               if (w_scl_fall) begin
                  if (rw_q == c_rw_read) begin
                     shift_d  = tx_data;
                     sda_oe_d = ~tx_data[7];
                     bitcnt_d = c_bitcnt_hi;
                     state_d  = S_TX_BYTE;
                  end else begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = c_bitcnt_hi;
                     done_d   = 1'b0;
                     state_d  = S_RX_BYTE;
                  end
               end
            end
            S_RX_ACK: begin
               if (w_scl_fall) begin
                  sda_oe_d = 1'b0;
                  bitcnt_d = c_bitcnt_hi;
                  done_d   = 1'b0;
                  state_d  = S_RX_BYTE;
               end
            end
            S_TX_BYTE: begin
               // bitcnt counts bits still to be launched after the current one
               if (w_scl_fall) begin
                  if (bitcnt_q == 3'd0) begin
                     sda_oe_d = 1'b0;
                     state_d  = S_TX_ACK;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                     bitcnt_d = bitcnt_q - 3'd1;
                  end
               end
            end
            S_TX_ACK: begin
               if (w_scl_rise) begin
                  if (w_sda_lvl == c_ack) tx_req_d = 1'b1;
                  else                    state_d  = S_WAIT_STOP;
               end else if (w_scl_fall) begin
                  shift_d  = tx_data;
                  sda_oe_d = ~tx_data[7];
                  bitcnt_d = c_bitcnt_hi;
                  state_d  = S_TX_BYTE;
               end
            end
            S_IDLE, S_WAIT_STOP: begin
            end
            default: begin
               state_d  = S_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// Module      : tb_i2c_target
// Description : Directed bus-master bench for i2c_target.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target;
   import i2c_pkg::*;

   localparam int Q = 20;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl   = 1'b1;
   logic       m_oe  = 1'b0;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   wire  [7:0] rx_data;
   wire        rx_valid;
   wire        tx_req;
   wire        busy;

   assign sda = m_oe ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_target #(.DEV_ADDR(7'h27)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl),
      .sda      (sda),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_req   (tx_req),
      .tx_data  (tx_data),
      .busy     (busy)
   );

   int n_chk = 0;
   int n_pass = 0;

   int         rx_cnt = 0;
   int         tx_cnt = 0;
   int         low_cnt = 0;
   int         busy_cnt = 0;
   int         wide_cnt = 0;
   logic       rxv_prev = 1'b0;
   logic [7:0] rx_log [0:15];

   function automatic logic [7:0] tx_byte(input int idx);
      case (idx)
         0:       tx_byte = 8'hC3;
         1:       tx_byte = 8'h5A;
         2:       tx_byte = 8'h99;
         default: tx_byte = 8'hFF;
      endcase
   endfunction

   always @(negedge clk) begin
      rxv_prev <= rx_valid;
      if (rx_valid && rxv_prev) wide_cnt <= wide_cnt + 1;
      if (rx_valid) begin
         rx_log[rx_cnt[3:0]] <= rx_data;
         rx_cnt <= rx_cnt + 1;
      end
      if (tx_req) begin
         tx_data <= tx_byte(tx_cnt);
         tx_cnt  <= tx_cnt + 1;
      end
      if (!m_oe && sda === 1'b0) low_cnt <= low_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: sim time exceeded, want finish before 5 ms");
      $fatal(1);
   end

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_oe = 1'b0; wq();
      scl  = 1'b1; wq();
      m_oe = 1'b1; wq();
      scl  = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      m_oe = 1'b1; wq();
      scl  = 1'b1; wq();
      m_oe = 1'b0; wq();
   endtask

   task automatic write_bit(input logic b);
      m_oe = ~b; wq();
      scl  = 1'b1; wq(); wq();
      scl  = 1'b0; wq();
   endtask

   task automatic read_bit(output logic b);
      m_oe = 1'b0; wq();
      scl  = 1'b1; wq();
      b    = sda;  wq();
      scl  = 1'b0; wq();
   endtask

   task automatic write_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] v, input logic mack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(mack);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h want 00", rx_data); else n_pass++;
      n_chk++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else n_pass++;
      n_chk++; if (tx_req !== 1'b0) $display("FAIL rst_tx_req: got %b want 0", tx_req); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_chk++; if (sda !== 1'b1) $display("FAIL rst_sda: got %b want 1 (released)", sda); else n_pass++;
      rst_n = 1'b1;
      wq();
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int   rx0;
      rx0 = rx_cnt;
      i2c_start();
      write_byte(8'h4E, a0);
      n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else n_pass++;
      write_byte(8'hA5, a1);
      write_byte(8'h3C, a2);
      i2c_stop();
      wq();
      n_chk++; if (a0 !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", a0); else n_pass++;
      n_chk++; if (a1 !== 1'b0) $display("FAIL wr_d0_ack: got %b want 0", a1); else n_pass++;
      n_chk++; if (a2 !== 1'b0) $display("FAIL wr_d1_ack: got %b want 0", a2); else n_pass++;
      n_chk++; if (rx_cnt - rx0 !== 2) $display("FAIL wr_rx_count: got %0d want 2", rx_cnt - rx0); else n_pass++;
      n_chk++; if (rx_log[rx0[3:0]] !== 8'hA5) $display("FAIL wr_rx0: got %h want a5", rx_log[rx0[3:0]]); else n_pass++;
      n_chk++; if (rx_log[rx0[3:0] + 4'd1] !== 8'h3C) $display("FAIL wr_rx1: got %h want 3c", rx_log[rx0[3:0] + 4'd1]); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_wrong_addr();
      logic a0, a1;
      int   rx0, low0, busy0;
      rx0 = rx_cnt; low0 = low_cnt; busy0 = busy_cnt;
      i2c_start();
      write_byte(8'h50, a0);
      write_byte(8'h11, a1);
      i2c_stop();
      wq();
      n_chk++; if (a0 !== 1'b1) $display("FAIL wa_addr_nack: got %b want 1", a0); else n_pass++;
      n_chk++; if (low_cnt - low0 !== 0) $display("FAIL wa_sda_low: got %0d low cycles want 0", low_cnt - low0); else n_pass++;
      n_chk++; if (rx_cnt - rx0 !== 0) $display("FAIL wa_rx_count: got %0d want 0", rx_cnt - rx0); else n_pass++;
      n_chk++; if (busy_cnt - busy0 !== 0) $display("FAIL wa_busy: got %0d busy cycles want 0", busy_cnt - busy0); else n_pass++;
   endtask

   task automatic test_read();
      logic       a0;
      logic [7:0] b0, b1;
      int         tx0;
      tx0 = tx_cnt;
      i2c_start();
      write_byte(8'h4F, a0);
      read_byte(b0, 1'b0);
      read_byte(b1, 1'b1);
      wq();
      n_chk++; if (sda !== 1'b1) $display("FAIL rd_sda_after_nack: got %b want 1", sda); else n_pass++;
      i2c_stop();
      n_chk++; if (a0 !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", a0); else n_pass++;
      n_chk++; if (b0 !== 8'hC3) $display("FAIL rd_byte0: got %b want 11000011", b0); else n_pass++;
      n_chk++; if (b1 !== 8'h5A) $display("FAIL rd_byte1: got %b want 01011010", b1); else n_pass++;
      n_chk++; if (tx_cnt - tx0 !== 2) $display("FAIL rd_tx_req_count: got %0d want 2", tx_cnt - tx0); else n_pass++;
   endtask

   task automatic test_repeated_start();
      logic       a0, a1, a2;
      logic [7:0] b0;
      int         rx0, tx0;
      rx0 = rx_cnt; tx0 = tx_cnt;
      i2c_start();
      write_byte(8'h4E, a0);
      write_byte(8'h01, a1);
      i2c_start();
      write_byte(8'h4F, a2);
      n_chk++; if (busy !== 1'b1) $display("FAIL rs_busy: got %b want 1", busy); else n_pass++;
      read_byte(b0, 1'b1);
      i2c_stop();
      wq();
      n_chk++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
      n_chk++; if (rx_cnt - rx0 !== 1) $display("FAIL rs_rx_count: got %0d want 1", rx_cnt - rx0); else n_pass++;
      n_chk++; if (rx_log[rx0[3:0]] !== 8'h01) $display("FAIL rs_rx_data: got %h want 01", rx_log[rx0[3:0]]); else n_pass++;
      n_chk++; if (b0 !== 8'h99) $display("FAIL rs_read: got %h want 99", b0); else n_pass++;
      n_chk++; if (tx_cnt - tx0 !== 1) $display("FAIL rs_tx_req_count: got %0d want 1", tx_cnt - tx0); else n_pass++;
   endtask

   task automatic test_abort();
      logic a0;
      int   rx0;
      rx0 = rx_cnt;
      i2c_start();
      write_byte(8'h4E, a0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      i2c_stop();
      wq();
      n_chk++; if (rx_cnt - rx0 !== 0) $display("FAIL ab_rx_count: got %0d want 0", rx_cnt - rx0); else n_pass++;
      n_chk++; if (dut.state_q !== S_IDLE) $display("FAIL ab_state: got %0d want %0d", dut.state_q, S_IDLE); else n_pass++;
      n_chk++; if (sda !== 1'b1) $display("FAIL ab_sda: got %b want 1", sda); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL ab_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_reset_during_ack();
      logic a0, a1;
      int   rx0;
      i2c_start();
      for (int i = 7; i >= 0; i--) write_bit(logic'(8'h4E >> i));
      m_oe = 1'b0; wq();
      scl  = 1'b1; wq();
      n_chk++; if (sda !== 1'b0) $display("FAIL rsa_ack_drive: got %b want 0", sda); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if (sda !== 1'b1) $display("FAIL rsa_sda_async: got %b want 1", sda); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rsa_busy: got %b want 0", busy); else n_pass++;
      n_chk++; if (rx_data !== 8'h00) $display("FAIL rsa_rx_data: got %h want 00", rx_data); else n_pass++;
      n_chk++; if ({rx_valid, tx_req} !== 2'b00) $display("FAIL rsa_pulses: got %b want 00", {rx_valid, tx_req}); else n_pass++;
      wq();
      @(negedge clk);
      rst_n = 1'b1;
      wq();
      rx0 = rx_cnt;
      i2c_start();
      write_byte(8'h4E, a0);
      write_byte(8'h77, a1);
      i2c_stop();
      wq();
      n_chk++; if ({a0, a1} !== 2'b00) $display("FAIL rsa_after_acks: got %b want 00", {a0, a1}); else n_pass++;
      n_chk++; if (rx_cnt - rx0 !== 1) $display("FAIL rsa_after_rx_count: got %0d want 1", rx_cnt - rx0); else n_pass++;
      n_chk++; if (rx_data !== 8'h77) $display("FAIL rsa_after_rx_data: got %h want 77", rx_data); else n_pass++;
   endtask

   task automatic test_pulse_width();
      n_chk++; if (wide_cnt !== 0) $display("FAIL rx_valid_width: got %0d multi-cycle pulses want 0", wide_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_wrong_addr();
      test_read();
      test_repeated_start();
      test_abort();
      test_reset_during_ack();
      test_pulse_width();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
